// File: rtl/piano_pkg.sv
// Shared types and constants for the keyboard note path: note bit order,
// the default buffer entry layout and the recorder state encoding.
package piano_pkg;

  localparam int NOTE_W    = 7;
  localparam int NOTE_A    = 6;
  localparam int NOTE_B    = 5;
  localparam int NOTE_C    = 4;
  localparam int NOTE_D    = 3;
  localparam int NOTE_E    = 2;
  localparam int NOTE_F    = 1;
  localparam int NOTE_G    = 0;
  localparam int DUR_W_DEF = 12;

  typedef struct packed {
    logic [NOTE_W-1:0]    notes;
    logic [DUR_W_DEF-1:0] dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_REC,
    ST_PLAY
  } rec_state_t;

endpackage

// File: rtl/tick_gen.sv
// Duration quantum generator: one-cycle tick every CLK_HZ/TICK_HZ clocks.
// While restart is high the divider reads as 0, so a tick lands DIV-1 cycles later.
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt, eff;

  always_comb begin
    eff  = restart ? '0 : cnt;
    tick = (eff == CW'(DIV - 1));
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else      cnt <= tick ? '0 : eff + 1'b1;

endmodule

// File: rtl/note_recorder.sv
// Records the synchronised key chords as {notes, duration} entries and replays
// them onto the tone-generator note enables with no gap cycles between entries.
module note_recorder import piano_pkg::*; #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int DEPTH   = 64,
  parameter int DUR_W   = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rec_en,
  input  logic                    play_start,
  input  logic                    clear,
  input  logic [NOTE_W-1:0]       notes_in,
  output logic [NOTE_W-1:0]       notes_out,
  output logic                    recording,
  output logic                    playing,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  typedef struct packed {
    logic [NOTE_W-1:0] notes;
    logic [DUR_W-1:0]  dur;
  } rec_entry_t;

  rec_state_t        state, prev_state;
  logic [NOTE_W-1:0] sync1, s, cur;
  logic [DUR_W-1:0]  dur, dur_inc, dur_left;
  logic [AW-1:0]     rd_ptr, rd_addr;
  logic [CW-1:0]     play_idx;
  logic              tick, restart, wr_en, do_wr, last_tick;
  rec_entry_t        wr_data, rd_q;
  rec_entry_t        mem [DEPTH];

  // Divider is realigned on every state entry.
  assign restart = (state != prev_state);

  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign dur_inc   = dur + 1'b1;
  assign last_tick = tick && (dur_left == DUR_W'(1) || dur_left == '0);
  // Outside PLAY entry 0 is kept prefetched so playback starts without a bubble.
  assign rd_addr   = (state == ST_PLAY) ? rd_ptr : '0;

  always_comb begin
    wr_en         = 1'b0;
    wr_data.notes = cur;
    wr_data.dur   = dur;
    if (state == ST_REC && !clear) begin
      if (!rec_en)
        wr_en = (dur != '0);
      else if (tick) begin
        if (s != cur) begin
          wr_en       = 1'b1;
          wr_data.dur = dur_inc;
        end else if (dur_inc == DUR_MAX) begin
          wr_en       = 1'b1;
          wr_data.dur = DUR_MAX;
        end
      end
    end
  end

  assign do_wr = wr_en && !full;

  always_ff @(posedge clk) begin
    if (do_wr) mem[count[AW-1:0]] <= wr_data;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      prev_state <= ST_IDLE;
      sync1      <= '0;
      s          <= '0;
      cur        <= '0;
      dur        <= '0;
      dur_left   <= '0;
      rd_ptr     <= '0;
      play_idx   <= '0;
      count      <= '0;
      full       <= 1'b0;
      notes_out  <= '0;
      recording  <= 1'b0;
      playing    <= 1'b0;
    end else begin
      sync1      <= notes_in;
      s          <= sync1;
      prev_state <= state;
      if (do_wr) begin
        count <= count + 1'b1;
        full  <= (count + 1'b1 == CW'(DEPTH));
      end
      if (clear) begin
        state     <= ST_IDLE;
        count     <= '0;
        full      <= 1'b0;
        notes_out <= '0;
        recording <= 1'b0;
        playing   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE:
            if (rec_en) begin
              state     <= ST_ARM;
              count     <= '0;
              full      <= 1'b0;
              recording <= 1'b1;
            end else if (play_start && count != '0) begin
              state     <= ST_PLAY;
              playing   <= 1'b1;
              notes_out <= rd_q.notes;
              dur_left  <= rd_q.dur;
              rd_ptr    <= AW'(1);
              play_idx  <= '0;
            end
          ST_ARM:
            if (!rec_en) begin
              state     <= ST_IDLE;
              recording <= 1'b0;
            end else if (s != '0) begin
              state <= ST_REC;
              cur   <= s;
              dur   <= '0;
            end
          ST_REC:
            // The closing flush write is issued by the write-enable logic.
            if (!rec_en) begin
              state     <= ST_IDLE;
              recording <= 1'b0;
            end else if (tick) begin
              if (s != cur) begin
                cur <= s;
                dur <= '0;
              end else if (dur_inc == DUR_MAX) dur <= '0;
              else                             dur <= dur_inc;
            end
          ST_PLAY:
            if (rec_en) begin
              state     <= ST_ARM;
              playing   <= 1'b0;
              recording <= 1'b1;
              notes_out <= '0;
              count     <= '0;
              full      <= 1'b0;
            end else if (last_tick) begin
              if (CW'(play_idx + 1'b1) == count) begin
                state     <= ST_IDLE;
                playing   <= 1'b0;
                notes_out <= '0;
              end else begin
                notes_out <= rd_q.notes;
                dur_left  <= rd_q.dur;
                rd_ptr    <= rd_ptr + 1'b1;
                play_idx  <= play_idx + 1'b1;
              end
            end else if (tick) dur_left <= dur_left - 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Captures the performer's key sequence (7 note switches) as {chord, duration} entries in an on-chip buffer.
- Replays the buffer on demand, driving the same 7-bit note-enable vector that feeds the per-note tone generators.
- Sits between the switch/LED path and the tone generators: the writer of a song, where the existing playback block is the reader of a fixed song.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 100, duration quantum rate (10 ms per tick).
- DEPTH, 64, number of buffer entries (power of 2).
- DUR_W, 12, duration field width in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- rec_en  in  1  level; high = record mode.
- play_start  in  1  single-cycle pulse; starts playback.
- clear  in  1  single-cycle pulse; empties the buffer.
- notes_in  in  7  raw switch levels; bit6 = A … bit0 = G.
- notes_out  out  7  note enables to the tone generators.
- recording  out  1  record state active.
- playing  out  1  playback state active.
- full  out  1  buffer holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  entries stored.

Behaviour:
- Reset (rst=0, async): all outputs 0, buffer empty, FSM in IDLE, tick counter 0.
- notes_in passes through a 2-flop synchroniser; all logic uses the synchronised value `s`.
- Tick: divider counts to CLK_HZ/TICK_HZ-1 and pulses `tick` for one cycle. The divider restarts at 0 on every state entry.
- FSM states: IDLE, ARM, REC, PLAY.
- Priority order: clear, then rec_en, then play_start.
- clear in any state:
  - count=0, full=0, notes_out=0, next state IDLE.
  - A clear in REC discards the pending entry.
- IDLE -> ARM when rec_en=1.
- ARM (recording=1): waits for s≠0. Leading silence is not stored.
  - On s≠0: cur=s, dur=0, go to REC.
  - rec_en=0 -> IDLE.
- REC (recording=1), on each tick:
  - If s==cur: dur++.
  - If dur reaches 2^DUR_W-1: write {cur, dur}, then dur=0. This splits long holds.
  - If s≠cur: write {cur, dur+1}, then cur=s, dur=0.
  - Silence (s=0) after the first note is recorded as a normal entry.
- rec_en falls in REC: write the pending entry if dur>0 (flush), then go to IDLE.
- Writes while full are dropped silently. full stays 1 and count does not change. Recording continues until rec_en=0.
- IDLE -> PLAY on play_start when count>0. With count=0, play_start is ignored.
  - Read pointer = 0.
- PLAY (playing=1):
  - notes_out = entry.notes, held for entry.dur ticks, then advance to the next entry.
  - A new entry is presented in the cycle after the last tick of the previous one. There are no gap cycles.
  - After the last entry: notes_out=0, then IDLE.
  - play_start during PLAY is ignored.
  - rec_en=1 during PLAY aborts playback: notes_out=0, go to ARM, and the buffer is overwritten from entry 0.
- Entering ARM always resets the write pointer and count to 0. A new take replaces the old one.
- notes_out is registered and is 0 in every state except PLAY.
- Buffer: DEPTH x (7+DUR_W). Synchronous write. Read is registered with 1-cycle latency; the read is prefetched so playback has no gaps.

Decomposition:
- Shared package piano_pkg holds:
  - NOTE_W=7 and the note bit order constants (A..G).
  - entry_t = {notes[6:0], dur[DUR_W-1:0]}.
  - State enum rec_state_t.
- Sub-module tick_gen(CLK_HZ, TICK_HZ) with ports clk, rst, restart, tick. This module is reusable by tone and playback blocks.

Test Plan (CLK_HZ=1000, TICK_HZ=100 -> tick every 10 clocks; DEPTH=4; DUR_W=4):
- Reset mid-PLAY: assert rst=0 -> same cycle notes_out=0, playing=0, count=0; after release play_start is ignored.
- Record: rec_en=1; notes_in=0 for 5 ticks, 0x40 for 3 ticks, 0x00 for 2 ticks, 0x41 for 4 ticks; rec_en=0 -> count=3 and entries {0x40,3},{0x00,2},{0x41,4}. The leading silence is not stored.
- Playback of that take: play_start -> notes_out=0x40 for 30 clk, 0x00 for 20 clk, 0x41 for 40 clk, then 0 with playing=0.
- Saturation: hold 0x10 for 20 ticks -> entries {0x10,15},{0x10,5}, count=2.
- Overflow: 6 distinct chords of 1 tick each -> count=4, full=1, the first 4 are stored, and a later play_start replays only those 4.
- Interrupts: rec_en=1 during PLAY -> notes_out=0 next cycle, recording=1, count=0. clear in REC -> count=0 and nothing is flushed on rec_en fall.
